// File: rtl/tt_pkg.sv
// Shared definitions for the truth-table self-test block: FSM state encoding
// and default sizing for a 3-input lab function.
package tt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } tt_state_e;

  localparam int DEF_N_IN   = 3;
  localparam int DEF_SETTLE = 2;

endpackage

// File: rtl/truth_table_checker_if.sv
// Control/result bundle of the truth-table checker. The master side requests
// runs and supplies the expected table; the slave side is the checker.
interface truth_table_checker_if #(
  parameter int N_IN = 3
) ();

  localparam int W = 1 << N_IN;

  logic            start;
  logic [W-1:0]    expected;
  logic            busy;
  logic            done;
  logic            pass;
  logic [W-1:0]    table_out;
  logic [N_IN:0]   mismatch_cnt;
  logic [N_IN-1:0] first_bad;

  modport master (
    output start, expected,
    input  busy, done, pass, table_out, mismatch_cnt, first_bad
  );

  modport slave (
    input  start, expected,
    output busy, done, pass, table_out, mismatch_cnt, first_bad
  );

endinterface

// File: rtl/tt_settle_timer.sv
// Settle counter: counts 0..SETTLE-1 while enabled and ticks on the last count,
// marking the cycle in which the held vector is sampled.
module tt_settle_timer #(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] LAST = CW'(SETTLE - 1);

  logic [CW-1:0] count_q, count_d;

  assign tick = en && (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (clear)   count_d = '0;
    else if (en) count_d = tick ? '0 : count_q + CW'(1);
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

endmodule

// File: rtl/truth_table_checker.sv
// Walks every input vector of a small combinational block, captures its truth
// table and compares it against a latched expected table.
module truth_table_checker
  import tt_pkg::*;
#(
  parameter int N_IN   = DEF_N_IN,
  parameter int SETTLE = DEF_SETTLE
) (
  input  logic                        clk,
  input  logic                        rst,
  truth_table_checker_if.slave        bus,
  input  logic                        f_in,
  output logic [N_IN-1:0]             stim
);

  localparam int W = 1 << N_IN;
  localparam logic [N_IN-1:0] V_LAST = N_IN'(W - 1);

  tt_state_e       state_q, state_d;
  logic [N_IN-1:0] v_q, v_d;
  logic [W-1:0]    exp_q, exp_d;
  logic [W-1:0]    table_q, table_d;
  logic            pass_q, pass_d;
  logic [N_IN:0]   mcnt_q, mcnt_d;
  logic [N_IN-1:0] fbad_q, fbad_d;

  logic            start_acc;
  logic            tick;
  logic [W-1:0]    sample_table;
  logic [W-1:0]    diff;
  logic [N_IN:0]   diff_cnt;
  logic [N_IN-1:0] diff_first;

  // A start is only honoured between runs, never as a restart.
  assign start_acc = bus.start && (state_q != ST_RUN);

  tt_settle_timer #(.SETTLE(SETTLE)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (start_acc),
    .en    (state_q == ST_RUN),
    .tick  (tick)
  );

  // Compare sees the bit being captured this cycle, so results are final at the last sample.
  always_comb begin
    sample_table       = table_q;
    sample_table[v_q]  = f_in;
    diff               = sample_table ^ exp_q;
    diff_cnt           = '0;
    diff_first         = '0;
    for (int i = 0; i < W; i++) begin
      diff_cnt = diff_cnt + (N_IN + 1)'(diff[i]);
    end
    for (int i = W - 1; i >= 0; i--) begin
      if (diff[i]) diff_first = N_IN'(i);
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    exp_d   = exp_q;
    table_d = table_q;
    pass_d  = pass_q;
    mcnt_d  = mcnt_q;
    fbad_d  = fbad_q;

    if (start_acc) begin
      state_d = ST_RUN;
      v_d     = '0;
      exp_d   = bus.expected;
      table_d = '0;
      pass_d  = 1'b0;
      mcnt_d  = '0;
      fbad_d  = '0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (tick) begin
            table_d = sample_table;
            if (v_q == V_LAST) begin
              state_d = ST_DONE;
              pass_d  = (diff == '0);
              mcnt_d  = diff_cnt;
              fbad_d  = diff_first;
            end else begin
              v_d = v_q + N_IN'(1);
            end
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      v_q     <= '0;
      exp_q   <= '0;
      table_q <= '0;
      pass_q  <= 1'b0;
      mcnt_q  <= '0;
      fbad_q  <= '0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      exp_q   <= exp_d;
      table_q <= table_d;
      pass_q  <= pass_d;
      mcnt_q  <= mcnt_d;
      fbad_q  <= fbad_d;
    end
  end

  assign stim             = (state_q == ST_RUN) ? v_q : '0;
  assign bus.busy         = (state_q == ST_RUN);
  assign bus.done         = (state_q == ST_DONE);
  assign bus.pass         = pass_q;
  assign bus.table_out    = table_q;
  assign bus.mismatch_cnt = mcnt_q;
  assign bus.first_bad    = fbad_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker: two instances (SETTLE=2 and SETTLE=1), each
// driving a table-defined lab function, checked against a high-level model.
module tb_truth_table_checker;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Instance A: N_IN=3, SETTLE=2
  truth_table_checker_if #(.N_IN(3)) ifa ();
  logic [2:0] stim_a;
  logic [7:0] fn_a;
  logic       f_a;
  assign f_a = fn_a[stim_a];

  truth_table_checker #(.N_IN(3), .SETTLE(2)) dut_a (
    .clk  (clk),
    .rst  (rst),
    .bus  (ifa.slave),
    .f_in (f_a),
    .stim (stim_a)
  );

  // Instance B: N_IN=3, SETTLE=1
  truth_table_checker_if #(.N_IN(3)) ifb ();
  logic [2:0] stim_b;
  logic [7:0] fn_b;
  logic       f_b;
  assign f_b = fn_b[stim_b];

  truth_table_checker #(.N_IN(3), .SETTLE(1)) dut_b (
    .clk  (clk),
    .rst  (rst),
    .bus  (ifb.slave),
    .f_in (f_b),
    .stim (stim_b)
  );

  // Reference: {pass, table, mismatch_cnt, first_bad} for a function table and expected table.
  function automatic logic [15:0] model(input logic [7:0] fn, input logic [7:0] ex);
    logic [7:0] d;
    logic [3:0] cnt;
    logic [2:0] fb;
    d   = fn ^ ex;
    cnt = 4'($countones(d));
    fb  = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (d[i]) begin
        fb = 3'(i);
        break;
      end
    end
    return {(d == 8'h00), fn, cnt, fb};
  endfunction

  function automatic logic [15:0] res_a();
    return {ifa.pass, ifa.table_out, ifa.mismatch_cnt, ifa.first_bad};
  endfunction

  function automatic logic [15:0] res_b();
    return {ifb.pass, ifb.table_out, ifb.mismatch_cnt, ifb.first_bad};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    ifa.start = 1'b1; ifa.expected = 8'hFF;
    ifb.start = 1'b1; ifb.expected = 8'hFF;
    fn_a = 8'hEA; fn_b = 8'hEA;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({ifa.busy, ifa.done, stim_a, res_a()} !== 21'd0) begin
      n_errors++;
      $display("FAIL reset_a: got %h want 0", {ifa.busy, ifa.done, stim_a, res_a()});
    end
    n_checks++;
    if ({ifb.busy, ifb.done, stim_b, res_b()} !== 21'd0) begin
      n_errors++;
      $display("FAIL reset_b: got %h want 0", {ifb.busy, ifb.done, stim_b, res_b()});
    end
    ifa.start = 1'b0;
    ifb.start = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({ifa.busy, ifb.busy} !== 2'b00) begin
      n_errors++;
      $display("FAIL reset_start_ignored: busy=%b want 00", {ifa.busy, ifb.busy});
    end
  endtask

  // One SETTLE=2 run on instance A. *_at give the edge offset from E0 (0 = unused).
  task automatic run_a(input string name, input logic [7:0] fn, input logic [7:0] ex,
                       input int restart_at, input int chg_at, input int rst_at);
    logic [15:0] want;
    logic [4:0]  ctl_want;
    bit          aborted = 0;
    want = model(fn, ex);
    fn_a = fn;
    ifa.expected = ex;
    ifa.start = 1'b1;
    for (int j = 0; j <= 17; j++) begin
      @(posedge clk); #1;
      ifa.start = 1'b0;
      if (rst_at > 0 && j == rst_at) begin
        rst = 1'b0;
        aborted = 1;
        n_checks++;
        if ({ifa.busy, ifa.done, stim_a, res_a()} !== 21'd0) begin
          n_errors++;
          $display("FAIL %s abort: got %h want 0", name, {ifa.busy, ifa.done, stim_a, res_a()});
        end
      end else if (aborted) begin
        n_checks++;
        if ({ifa.busy, ifa.done} !== 2'b00) begin
          n_errors++;
          $display("FAIL %s post_abort j=%0d: busy,done=%b want 00", name, j, {ifa.busy, ifa.done});
        end
      end else begin
        if (j < 16)       ctl_want = {1'b1, 1'b0, 3'(j / 2)};
        else if (j == 16) ctl_want = 5'b01_000;
        else              ctl_want = 5'b00_000;
        n_checks++;
        if ({ifa.busy, ifa.done, stim_a} !== ctl_want) begin
          n_errors++;
          $display("FAIL %s ctl j=%0d: busy,done,stim=%b want %b", name, j,
                   {ifa.busy, ifa.done, stim_a}, ctl_want);
        end
        if (j >= 16) begin
          n_checks++;
          if (res_a() !== want) begin
            n_errors++;
            $display("FAIL %s result j=%0d: pass,table,cnt,first=%h want %h", name, j, res_a(), want);
          end
        end
      end
      if (j + 1 == restart_at) ifa.start = 1'b1;
      if (j + 1 == chg_at)     ifa.expected = 8'h00;
      if (j + 1 == rst_at)     rst = 1'b1;
    end
    ifa.start = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_directed();
    run_a("match",      8'hEA, 8'hEA, 0, 0, 0);
    run_a("exp_eb",     8'hEA, 8'hEB, 0, 0, 0);
    run_a("exp_6a",     8'hEA, 8'h6A, 0, 0, 0);
    run_a("complement", 8'hEA, 8'h15, 0, 0, 0);
  endtask

  task automatic test_ignore_during_run();
    run_a("restart_chg", 8'hEA, 8'hEA, 5, 6, 0);
  endtask

  task automatic test_abort();
    run_a("abort",       8'hEA, 8'hEA, 0, 0, 7);
    run_a("after_abort", 8'hEA, 8'hEA, 0, 0, 0);
  endtask

  task automatic test_random();
    logic [7:0] fn, ex;
    for (int k = 0; k < 8; k++) begin
      fn = 8'($urandom);
      ex = (k % 3 == 0) ? fn : 8'($urandom);
      run_a($sformatf("rand%0d", k), fn, ex, 0, 0, 0);
    end
  endtask

  // SETTLE=1: one vector per cycle, then a start during DONE chains a second run.
  task automatic test_back_to_back();
    logic [7:0] fn1, ex1, fn2, ex2;
    logic [4:0] ctl_want;
    fn1 = 8'hEA; ex1 = 8'hEA;
    fn2 = 8'($urandom); ex2 = 8'($urandom);
    fn_b = fn1;
    ifb.expected = ex1;
    ifb.start = 1'b1;
    for (int j = 0; j <= 18; j++) begin
      @(posedge clk); #1;
      ifb.start = 1'b0;
      if (j < 8)       ctl_want = {2'b10, 3'(j)};
      else if (j == 8) ctl_want = 5'b01_000;
      else if (j < 17) ctl_want = {2'b10, 3'(j - 9)};
      else if (j == 17) ctl_want = 5'b01_000;
      else             ctl_want = 5'b00_000;
      n_checks++;
      if ({ifb.busy, ifb.done, stim_b} !== ctl_want) begin
        n_errors++;
        $display("FAIL b2b ctl j=%0d: busy,done,stim=%b want %b", j, {ifb.busy, ifb.done, stim_b}, ctl_want);
      end
      if (j == 8) begin
        n_checks++;
        if (res_b() !== model(fn1, ex1)) begin
          n_errors++;
          $display("FAIL b2b run1: got %h want %h", res_b(), model(fn1, ex1));
        end
        fn_b = fn2;
        ifb.expected = ex2;
        ifb.start = 1'b1;
      end
      if (j == 17 || j == 18) begin
        n_checks++;
        if (res_b() !== model(fn2, ex2)) begin
          n_errors++;
          $display("FAIL b2b run2 j=%0d: got %h want %h", j, res_b(), model(fn2, ex2));
        end
      end
    end
    ifb.start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_during_run();
    test_abort();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
